calculo_arbiter: RTL and testbench

CALCULO_ARBITER -- requirements
Module: calculo_arbiter

---
 rtl/calculo_arbiter.sv | 151 +++++++++++++++
 tb/tb_calculo_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/calculo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calculo_arbiter
// Brief    : Two-requester round-robin arbiter for ((A*B)+C)*D on one shared
//            W x 3W multiplier and one 3W adder.
// Revision : 1.0 - initial release
// ============================================================================
module calculo_arbiter #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   c0,
    input  logic [W-1:0]   d0,
    input  logic           req1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    input  logic [W-1:0]   c1,
    input  logic [W-1:0]   d1,
    output logic [3*W-1:0] sal,
    output logic           done0,
    output logic           done1,
    output logic           busy,
    output logic           owner
);

    localparam int c_res_w = 3 * W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_ADD  = 3'd2,
        S_MUL2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [c_res_w-1:0]   p_q, p_d;
    logic [c_res_w-1:0]   sal_q, sal_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic                 busy_q, busy_d;
    logic                 owner_q, owner_d;

    logic                 w_gnt;
    logic [W-1:0]         w_mul_x;
    logic [c_res_w-1:0]   w_mul_y;
    logic [c_res_w-1:0]   w_mul_res;
    logic [c_res_w-1:0]   w_add_res;

    // Tie goes to the requester that was not served last.
    assign w_gnt = (req0 && req1) ? ~owner_q : req1;

    // The single multiplier is steered by state: A*B in MUL1, D*p in MUL2.
    always_comb begin
        w_mul_x = a_q;
        w_mul_y = {{(c_res_w-W){1'b0}}, b_q};
        if (state_q == S_MUL2) begin
            w_mul_x = d_q;
            w_mul_y = p_q;
        end
    end

    assign w_mul_res = {{(c_res_w-W){1'b0}}, w_mul_x} * w_mul_y;
    assign w_add_res = p_q + {{(c_res_w-W){1'b0}}, c_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        p_d     = p_q;
        sal_d   = sal_q;
        owner_d = owner_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = w_gnt;
                    a_d     = w_gnt ? a1 : a0;
                    b_d     = w_gnt ? b1 : b0;
                    c_d     = w_gnt ? c1 : c0;
                    d_d     = w_gnt ? d1 : d0;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: begin
                p_d     = w_mul_res;
                state_d = S_ADD;
            end
            S_ADD: begin
                p_d     = w_add_res;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                sal_d   = w_mul_res;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_MUL1) || (state_d == S_ADD) || (state_d == S_MUL2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            sal_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            p_q     <= p_d;
            sal_q   <= sal_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign sal   = sal_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_calculo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculo_arbiter
// Brief    : Directed self-checking bench for calculo_arbiter (W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculo_arbiter;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, c0 = '0, d0 = '0;
    logic [W-1:0]   a1 = '0, b1 = '0, c1 = '0, d1 = '0;
    logic [3*W-1:0] sal;
    logic           done0, done1, busy, owner;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_g = -1;

    calculo_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .c0(c0), .d0(d0),
        .req1(req1), .a1(a1), .b1(b1), .c1(c1), .d1(d1),
        .sal(sal), .done0(done0), .done1(done1), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs until a done pulse, then one more cycle (DONE -> IDLE).
    task automatic do_op(input string tag, input int who, input int exp_sal,
                         input bit drop, input int exp_gap, input bit scramble);
        int n  = 0;
        int g  = -1;
        int bc = 0;
        while (!(done0 || done1) && n < 20) begin
            tick();
            n++;
            if (busy) begin
                bc++;
                if (g < 0) begin
                    g = cyc;
                    if (scramble) begin
                        a0 = '0; b0 = '0; c0 = '0; d0 = '0;
                        a1 = '0; b1 = '0; c1 = '0; d1 = '0;
                    end
                end
            end
        end
        chk({tag, "_no_timeout"}, (n < 20), 1);
        chk({tag, "_done_vec"}, {done1, done0}, (who != 0) ? 2 : 1);
        chk({tag, "_sal"}, sal, exp_sal);
        chk({tag, "_owner"}, owner, who);
        chk({tag, "_latency"}, cyc - g, 3);
        chk({tag, "_busy_cycles"}, bc, 3);
        if (exp_gap > 0) chk({tag, "_grant_gap"}, g - last_g, exp_gap);
        last_g = g;
        if (drop) begin
            if (who != 0) req1 = 1'b0; else req0 = 1'b0;
        end
        tick();
        chk({tag, "_done_cleared"}, {done1, done0}, 0);
        chk({tag, "_busy_in_done"}, busy, 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_sal", sal, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 1);

        // Simultaneous requests right out of reset: requester 0 first
        a0 = 2'd1; b0 = 2'd2; c0 = 2'd1; d0 = 2'd2;   // (2+1)*2 = 6
        a1 = 2'd3; b1 = 2'd2; c1 = 2'd1; d1 = 2'd3;   // (6+1)*3 = 21
        req0 = 1'b1; req1 = 1'b1;
        rst = 1'b0;
        do_op("tie0", 0, 6, 1'b1, 0, 1'b0);
        do_op("tie1", 1, 21, 1'b1, 5, 1'b0);

        // Single requester 0, operands disturbed after the grant
        a0 = 2'd3; b0 = 2'd3; c0 = 2'd3; d0 = 2'd3;   // (9+3)*3 = 36
        req0 = 1'b1;
        do_op("r0_33", 0, 36, 1'b1, 0, 1'b1);

        // Single requester 1
        a1 = 2'd2; b1 = 2'd1; c1 = 2'd3; d1 = 2'd2;   // (2+3)*2 = 10
        req1 = 1'b1;
        do_op("r1", 1, 10, 1'b1, 0, 1'b0);

        // Both held continuously: grants alternate 0,1,0,1
        a0 = 2'd2; b0 = 2'd2; c0 = 2'd1; d0 = 2'd3;   // (4+1)*3 = 15
        a1 = 2'd1; b1 = 2'd1; c1 = 2'd0; d1 = 2'd3;   // (1+0)*3 = 3
        req0 = 1'b1; req1 = 1'b1;
        do_op("rr_a", 0, 15, 1'b0, 0, 1'b0);
        do_op("rr_b", 1, 3, 1'b0, 5, 1'b0);
        do_op("rr_c", 0, 15, 1'b0, 5, 1'b0);
        do_op("rr_d", 1, 3, 1'b0, 5, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Reset in ADD aborts the operation
        a0 = 2'd3; b0 = 2'd3; c0 = 2'd3; d0 = 2'd3;
        req0 = 1'b1;
        tick();                      // grant -> MUL1
        chk("abort_busy_mul1", busy, 1);
        tick();                      // -> ADD
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sal", sal, 0);
        chk("abort_done", {done1, done0}, 0);
        chk("abort_owner", owner, 1);
        do_op("reissue", 0, 36, 1'b1, 0, 1'b0);

        // Zero operands
        a0 = 2'd3; b0 = 2'd3; c0 = 2'd3; d0 = 2'd0;
        req0 = 1'b1;
        do_op("zero_d", 0, 0, 1'b1, 0, 1'b0);
        a0 = 2'd3; b0 = 2'd3; c0 = 2'd3; d0 = 2'd3;
        req0 = 1'b1;
        do_op("refill", 0, 36, 1'b1, 0, 1'b0);
        a0 = 2'd0; b0 = 2'd3; c0 = 2'd0; d0 = 2'd3;
        req0 = 1'b1;
        do_op("zero_ac", 0, 0, 1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
